ed25519_sign_s_ctrl: RTL and testbench

ED25519_SIGN_S_CTRL -- requirements
Module: ed25519_sign_s_ctrl

---
 rtl/ed25519_sign_s_ctrl.sv | 144 ++++++++++++++
 tb/tb_ed25519_sign_s_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ed25519_sign_s_ctrl.sv
// Request/response controller for the Ed25519 S computation core: latches operands, starts the
// core once, holds the result until taken. Optional RUN timeout via ED25519_SIGN_S_TIMEOUT_EN.
module ed25519_sign_s_ctrl #(
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_req_valid,
  output logic         o_req_ready,
  input  logic [250:0] i_hashd_key,
  input  logic [511:0] i_hashd_ram,
  input  logic [511:0] i_hashd_sm,
  output logic         o_rsp_valid,
  input  logic         i_rsp_ready,
  output logic [252:0] o_sign,
  output logic         o_err,
  output logic         o_core_en,
  input  logic         i_core_ready,
  input  logic         i_core_done,
  output logic [250:0] o_core_hashd_key,
  output logic [511:0] o_core_hashd_ram,
  output logic [511:0] o_core_hashd_sm,
  input  logic [252:0] i_core_sign,
  output logic         o_busy
);

  typedef enum logic [2:0] {StIdle, StWaitRdy, StStart, StRun, StHold} state_e;

  state_e       r_state;
  state_e       w_state_nxt;
  logic         w_accept;
  logic         w_timeout;
  logic [250:0] r_key;
  logic [511:0] r_ram;
  logic [511:0] r_sm;
  logic [252:0] r_sign;

  assign w_accept = i_req_valid & o_req_ready;

`ifdef ED25519_SIGN_S_TIMEOUT_EN
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_inc;
  logic        r_err;

  assign w_cnt_inc = r_cnt + 16'd1;
  assign w_timeout = (r_state == StRun) && (w_cnt_inc == TIMEOUT_CYC);

  // Cleared in START so the first RUN cycle counts as 1.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= 16'd0;
    end else if (r_state == StStart) begin
      r_cnt <= 16'd0;
    end else if (r_state == StRun) begin
      r_cnt <= w_cnt_inc;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else if (r_state == StRun) begin
      if (i_core_done) begin
        r_err <= 1'b0;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_err = r_err;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = ^TIMEOUT_CYC;
  assign w_timeout        = 1'b0;
  assign o_err            = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:    if (w_accept) w_state_nxt = StWaitRdy;
      StWaitRdy: if (i_core_ready) w_state_nxt = StStart;
      StStart:   w_state_nxt = StRun;
      StRun:     if (i_core_done || w_timeout) w_state_nxt = StHold;
      StHold:    if (i_rsp_ready) w_state_nxt = StIdle;
      default:   w_state_nxt = StIdle;
    endcase
  end

  // Ready is masked while reset is asserted so nothing can be accepted under reset.
  always_comb begin
    o_req_ready = 1'b0;
    o_core_en   = 1'b0;
    o_rsp_valid = 1'b0;
    o_busy      = 1'b1;
    unique case (r_state)
      StIdle: begin
        o_req_ready = ~i_rst;
        o_busy      = 1'b0;
      end
      StStart: o_core_en   = 1'b1;
      StHold:  o_rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_key  <= '0;
      r_ram  <= '0;
      r_sm   <= '0;
      r_sign <= '0;
    end else begin
      if (w_accept) begin
        r_key <= i_hashd_key;
        r_ram <= i_hashd_ram;
        r_sm  <= i_hashd_sm;
      end
      if (r_state == StRun) begin
        if (i_core_done) begin
          r_sign <= i_core_sign;
        end else if (w_timeout) begin
          r_sign <= '0;
        end
      end
    end
  end

  assign o_core_hashd_key = r_key;
  assign o_core_hashd_ram = r_ram;
  assign o_core_hashd_sm  = r_sm;
  assign o_sign           = r_sign;

endmodule

// File: tb/tb_ed25519_sign_s_ctrl.sv
// Scoreboard bench for ed25519_sign_s_ctrl: driver pushes expected {err, sign} per request,
// a monitor pops on each new response. Timeout cases run when ED25519_SIGN_S_TIMEOUT_EN is set.
module tb_ed25519_sign_s_ctrl;

  localparam logic [15:0] TCYC = 16'd20;
`ifdef ED25519_SIGN_S_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [250:0] hashd_key;
  logic [511:0] hashd_ram;
  logic [511:0] hashd_sm;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [252:0] sign;
  logic         err;
  logic         core_en;
  logic         core_ready;
  logic         core_done;
  logic [250:0] core_key;
  logic [511:0] core_ram;
  logic [511:0] core_sm;
  logic [252:0] core_sign;
  logic         busy;

  ed25519_sign_s_ctrl #(.TIMEOUT_CYC(TCYC)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_req_valid     (req_valid),
    .o_req_ready     (req_ready),
    .i_hashd_key     (hashd_key),
    .i_hashd_ram     (hashd_ram),
    .i_hashd_sm      (hashd_sm),
    .o_rsp_valid     (rsp_valid),
    .i_rsp_ready     (rsp_ready),
    .o_sign          (sign),
    .o_err           (err),
    .o_core_en       (core_en),
    .i_core_ready    (core_ready),
    .i_core_done     (core_done),
    .o_core_hashd_key(core_key),
    .o_core_hashd_ram(core_ram),
    .o_core_hashd_sm (core_sm),
    .i_core_sign     (core_sign),
    .o_busy          (busy)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  int           en_pulses = 0;
  int           n_started = 0;
  logic [253:0] exp_q[$];
  logic [253:0] last_exp = '0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v = {v[479:0], $urandom};
    return v;
  endfunction

  // Response monitor: compares on the first HOLD cycle, then checks the result stays put.
  initial begin
    logic         prev_valid;
    logic [253:0] cur_exp;
    prev_valid = 1'b0;
    cur_exp    = '0;
    forever begin
      @(negedge clk);
      if (core_en) en_pulses++;
      if (rsp_valid) begin
        if (!prev_valid) begin
          if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 512'(1), 512'(0));
            cur_exp = {err, sign};
          end else begin
            cur_exp = exp_q.pop_front();
            chk("rsp_sign", 512'(sign), 512'(cur_exp[252:0]));
            chk("rsp_err", 512'(err), 512'(cur_exp[253]));
          end
        end else begin
          chk("rsp_stable", 512'({err, sign}), 512'(cur_exp));
        end
      end
      prev_valid = rsp_valid;
    end
  end

  // d: cycles core_ready stays low after accept; k: RUN cycle carrying core_done;
  // hold: HOLD cycles before the consumer takes the result (>= 1).
  task automatic do_txn(input int d, input int k, input int hold, input logic [250:0] key,
                        input logic [511:0] ram, input logic [511:0] sm, input logic [252:0] s);
    logic [511:0] tmp;
    logic [253:0] exp;
    bit           to;
    int           n;
    int           en_c;
    int           hv_r;
    int           exp_r;
    to    = TO_EN && (k > int'(TCYC));
    exp   = to ? {1'b1, 253'd0} : {1'b0, s};
    exp_r = to ? int'(TCYC) + 1 : k + 1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", 512'(req_ready), 512'(1));
    if (!req_ready) return;
    exp_q.push_back(exp);
    n_started++;
    req_valid  = 1'b1;
    hashd_key  = key;
    hashd_ram  = ram;
    hashd_sm   = sm;
    core_ready = 1'b0;
    en_c = -1;
    for (int c = 1; c <= d + 10; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      tmp = rand512();
      hashd_key = tmp[250:0];
      hashd_ram = rand512();
      hashd_sm  = rand512();
      if (core_en) begin
        en_c = c;
        break;
      end
      core_ready = (c > d);
      core_done  = 1'($urandom);
    end
    chk("core_en_latency", 512'(en_c), 512'(d + 2));
    chk("core_key", 512'(core_key), 512'(key));
    chk("core_ram", core_ram, ram);
    chk("core_sm", core_sm, sm);
    core_done  = 1'($urandom);
    core_ready = 1'($urandom);
    hv_r = -1;
    for (int r = 1; r <= exp_r + 5; r++) begin
      @(negedge clk);
      if (r == 1) chk("core_en_single", 512'(core_en), 512'(0));
      if (rsp_valid) begin
        hv_r = r;
        break;
      end
      tmp        = rand512();
      core_done  = (!to && r == k);
      core_sign  = (r == k) ? s : tmp[252:0];
      core_ready = 1'($urandom);
    end
    chk("rsp_latency", 512'(hv_r), 512'(exp_r));
    for (int h = 1; h <= hold; h++) begin
      if (h > 1) @(negedge clk);
      tmp       = rand512();
      rsp_ready = (h == hold);
      core_done = 1'($urandom);
      core_sign = tmp[252:0];
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    core_done = 1'b0;
    chk("rsp_drop", 512'(rsp_valid), 512'(0));
    chk("idle_ready", 512'(req_ready), 512'(1));
    last_exp = exp;
  endtask

  task automatic idle_stray(input int n);
    logic [511:0] tmp;
    for (int i = 0; i < n; i++) begin
      tmp        = rand512();
      core_done  = 1'($urandom);
      rsp_ready  = 1'($urandom);
      core_ready = 1'($urandom);
      core_sign  = tmp[252:0];
      @(negedge clk);
      chk("stray_rsp_valid", 512'(rsp_valid), 512'(0));
      chk("stray_busy", 512'(busy), 512'(0));
      chk("stray_result", 512'({err, sign}), 512'(last_exp));
    end
    core_done = 1'b0;
    rsp_ready = 1'b0;
  endtask

  task automatic reset_in_run();
    logic [511:0] tmp;
    @(negedge clk);
    req_valid  = 1'b1;
    hashd_key  = 251'd7;
    hashd_ram  = 512'd8;
    hashd_sm   = 512'd9;
    core_ready = 1'b1;
    n_started++;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rr_core_en", 512'(core_en), 512'(1));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rr_ready_low", 512'(req_ready), 512'(0));
    chk("rr_rsp_valid", 512'(rsp_valid), 512'(0));
    chk("rr_busy", 512'(busy), 512'(0));
    chk("rr_core_key", 512'(core_key), 512'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("rr_ready_high", 512'(req_ready), 512'(1));
    tmp       = rand512();
    core_done = 1'b1;
    core_sign = tmp[252:0];
    @(negedge clk);
    core_done = 1'b0;
    chk("rr_done_ignored", 512'(rsp_valid), 512'(0));
    chk("rr_sign_zero", 512'({err, sign}), 512'(0));
    last_exp = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] t0;
    logic [511:0] t1;
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; core_ready = 1'b0; core_done = 1'b0;
    hashd_key = '0; hashd_ram = '0; hashd_sm = '0; core_sign = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 512'(req_ready), 512'(0));
    chk("reset_rsp_valid", 512'(rsp_valid), 512'(0));
    chk("reset_core_en", 512'(core_en), 512'(0));
    chk("reset_busy", 512'(busy), 512'(0));
    chk("reset_result", 512'({err, sign}), 512'(0));
    chk("reset_operands", core_ram | core_sm | 512'(core_key), 512'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", 512'(req_ready), 512'(1));

    do_txn(0, 3, 6, 251'd1, 512'd2, 512'd3, 253'h1234);
    idle_stray(6);
    do_txn(10, 2, 1, 251'd5, 512'd6, 512'd7, 253'h55aa);
    reset_in_run();
    if (TO_EN) begin
      do_txn(0, int'(TCYC), 2, 251'd11, 512'd12, 512'd13, 253'hbeef);
      do_txn(1, int'(TCYC) + 15, 2, 251'd14, 512'd15, 512'd16, 253'hcafe);
    end
    for (int i = 0; i < 25; i++) begin
      t0 = rand512();
      t1 = rand512();
      do_txn(int'($urandom_range(0, 4)), int'($urandom_range(1, 30)),
             int'($urandom_range(1, 4)), t0[250:0], rand512(), t1, t0[511:259]);
      if ($urandom_range(0, 3) == 0) idle_stray(2);
    end
    repeat (2) @(negedge clk);
    chk("queue_empty", 512'(exp_q.size()), 512'(0));
    chk("core_en_count", 512'(en_pulses), 512'(n_started));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
